// File: rtl/int_add.sv
`default_nettype none
// ============================================================================
// Module   : int_add
// Purpose  : Packed-SIMD integer adder, 4x32-bit with status flags, or
//            32x (4-bit + 8-bit) across two destination registers.
//            Optional macro INTADD_ST_FLAGS_EN enables 32-bit status flags.
// Revision : 1.0 - initial release
// ============================================================================
module int_add (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] src_reg0,
    input  logic [127:0] src_reg1,
    input  logic [127:0] src_reg2,
    input  logic [1:0]   precision_s0,
    input  logic [1:0]   precision_s1,
    input  logic [1:0]   precision_s2,
    input  logic         sign_s0,
    input  logic         sign_s1,
    input  logic         sign_s2,
    input  logic         inst_valid,
    output logic [127:0] dst_reg0,
    output logic [127:0] dst_reg1,
    output logic [127:0] st
);

    localparam logic [1:0] PREC_32  = 2'b11;
    localparam logic [1:0] PREC_4_8 = 2'b00;

    logic [127:0] sum32;
    logic [127:0] flags32;
    logic [127:0] sum8_lo;
    logic [127:0] sum8_hi;

    // Mode is decoded from precision_s0 only; an 8-bit byte's extension to
    // 8 bits is itself, so sign_s2 has no effect on a mod-256 result.
    logic unused_inputs;
    assign unused_inputs = ^{precision_s1, precision_s2, sign_s2};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [33:0] a_ext;
        logic [33:0] b_ext;
        logic [33:0] e;

        assign a_ext = {{2{sign_s0 & src_reg0[32*i+31]}}, src_reg0[32*i +: 32]};
        assign b_ext = {{2{sign_s1 & src_reg1[32*i+31]}}, src_reg1[32*i +: 32]};
        assign e     = a_ext + b_ext;
        assign sum32[32*i +: 32] = e[31:0];

`ifdef INTADD_ST_FLAGS_EN
        logic ovf;
        // Signed range holds when the top three bits agree; unsigned when
        // nothing spilled above bit 31.
        assign ovf = (sign_s0 | sign_s1) ? ~((e[33] == e[32]) && (e[32] == e[31]))
                                         : (e[33] | e[32]);
        assign flags32[32*i +: 32] = {29'd0, e[33], ~|e[31:0], ovf};
`else
        logic lane_unused;
        assign lane_unused = ^e[33:32];
        assign flags32[32*i +: 32] = 32'd0;
`endif
    end

    for (genvar i = 0; i < 16; i++) begin : g_byte
        logic [3:0] nib_lo;
        logic [3:0] nib_hi;

        assign nib_lo = src_reg0[4*i +: 4];
        assign nib_hi = src_reg0[4*(i+16) +: 4];
        assign sum8_lo[8*i +: 8] = {{4{sign_s0 & nib_lo[3]}}, nib_lo} + src_reg1[8*i +: 8];
        assign sum8_hi[8*i +: 8] = {{4{sign_s0 & nib_hi[3]}}, nib_hi} + src_reg2[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_reg0 <= '0;
            dst_reg1 <= '0;
            st       <= '0;
        end else if (inst_valid) begin
            case (precision_s0)
                PREC_32: begin
                    dst_reg0 <= sum32;
                    dst_reg1 <= '0;
                    st       <= flags32;
                end
                PREC_4_8: begin
                    dst_reg0 <= sum8_lo;
                    dst_reg1 <= sum8_hi;
                    st       <= '0;
                end
                default: begin
                    dst_reg0 <= '0;
                    dst_reg1 <= '0;
                    st       <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_add
// Purpose  : Self-checking bench for int_add: directed vector table,
//            control sequences and randomized checks against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_add;

`ifdef INTADD_ST_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [127:0] s0;
        logic [127:0] s1;
        logic [127:0] s2;
        logic [1:0]   prec;
        logic [1:0]   prec1;
        logic [1:0]   prec2;
        logic         sg0;
        logic         sg1;
        logic         sg2;
    } in_t;

    typedef struct {
        logic [127:0] d0;
        logic [127:0] d1;
        logic [127:0] st;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] src_reg0, src_reg1, src_reg2;
    logic [1:0]   precision_s0, precision_s1, precision_s2;
    logic         sign_s0, sign_s1, sign_s2;
    logic         inst_valid;
    logic [127:0] dst_reg0, dst_reg1, st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_add dut (
        .clk(clk), .rst(rst),
        .src_reg0(src_reg0), .src_reg1(src_reg1), .src_reg2(src_reg2),
        .precision_s0(precision_s0), .precision_s1(precision_s1), .precision_s2(precision_s2),
        .sign_s0(sign_s0), .sign_s1(sign_s1), .sign_s2(sign_s2),
        .inst_valid(inst_valid),
        .dst_reg0(dst_reg0), .dst_reg1(dst_reg1), .st(st)
    );

    // Reference model straight from the arithmetic rules, using 64-bit integers.
    function automatic out_t model(in_t x);
        out_t   r;
        longint a, b, e;
        int     p, q;
        logic [31:0] la, lb;
        logic [3:0]  n;
        logic [7:0]  y;
        logic [63:0] eb;
        r.d0 = '0; r.d1 = '0; r.st = '0;
        if (x.prec == 2'b11) begin
            for (int i = 0; i < 4; i++) begin
                la = x.s0[32*i +: 32];
                lb = x.s1[32*i +: 32];
                a  = x.sg0 ? longint'($signed(la)) : longint'({32'd0, la});
                b  = x.sg1 ? longint'($signed(lb)) : longint'({32'd0, lb});
                e  = a + b;
                eb = e;
                r.d0[32*i +: 32] = eb[31:0];
                if (FLAGS) begin
                    if (x.sg0 | x.sg1)
                        r.st[32*i] = (e < -(64'sd1 <<< 31)) || (e > (64'sd1 <<< 31) - 1);
                    else
                        r.st[32*i] = (e < 0) || (e > (64'sd1 <<< 32) - 1);
                    r.st[32*i+1] = (eb[31:0] == 32'd0);
                    r.st[32*i+2] = (e < 0);
                end
            end
        end else if (x.prec == 2'b00) begin
            for (int i = 0; i < 16; i++) begin
                n = x.s0[4*i +: 4];
                y = x.s1[8*i +: 8];
                p = x.sg0 ? int'($signed(n)) : int'(n);
                q = x.sg1 ? int'($signed(y)) : int'(y);
                r.d0[8*i +: 8] = 8'((p + q) & 255);
                n = x.s0[4*(i+16) +: 4];
                y = x.s2[8*i +: 8];
                p = x.sg0 ? int'($signed(n)) : int'(n);
                q = x.sg2 ? int'($signed(y)) : int'(y);
                r.d1[8*i +: 8] = 8'((p + q) & 255);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] stl(logic [2:0] l3, logic [2:0] l2,
                                         logic [2:0] l1, logic [2:0] l0);
        logic [127:0] v;
        v = '0;
        if (FLAGS) begin
            v[2:0] = l0; v[34:32] = l1; v[66:64] = l2; v[98:96] = l3;
        end
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(string name, out_t e);
        chk({name, ".dst_reg0"}, dst_reg0, e.d0);
        chk({name, ".dst_reg1"}, dst_reg1, e.d1);
        chk({name, ".st"}, st, e.st);
    endtask

    task automatic drive(in_t x, logic v);
        src_reg0 = x.s0; src_reg1 = x.s1; src_reg2 = x.s2;
        precision_s0 = x.prec; precision_s1 = x.prec1; precision_s2 = x.prec2;
        sign_s0 = x.sg0; sign_s1 = x.sg1; sign_s2 = x.sg2;
        inst_valid = v;
    endtask

    task automatic issue(in_t x);
        @(negedge clk);
        drive(x, 1'b1);
        @(posedge clk);
        #1;
    endtask

    function automatic in_t mk(logic [127:0] a, logic [127:0] b, logic [127:0] c,
                               logic [1:0] p, logic g0, logic g1, logic g2);
        in_t x;
        x.s0 = a; x.s1 = b; x.s2 = c; x.prec = p;
        x.prec1 = 2'b01; x.prec2 = 2'b10;
        x.sg0 = g0; x.sg1 = g1; x.sg2 = g2;
        return x;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic in_t rand_in();
        in_t x;
        logic [1:0] precs [6];
        precs = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            x.s0[32*i +: 32] = pick32();
            x.s1[32*i +: 32] = pick32();
            x.s2[32*i +: 32] = $urandom;
        end
        x.prec  = precs[$urandom_range(0, 5)];
        x.prec1 = 2'($urandom);
        x.prec2 = 2'($urandom);
        x.sg0 = 1'($urandom); x.sg1 = 1'($urandom); x.sg2 = 1'($urandom);
        return x;
    endfunction

    vec_t tbl[$];
    vec_t v;
    out_t held, zero;
    in_t  x;

    initial begin
        zero.d0 = '0; zero.d1 = '0; zero.st = '0;
        rst = 1'b1;
        drive(mk('0, '0, '0, 2'b11, 1'b0, 1'b0, 1'b0), 1'b0);

        v.name = "sat_pos";
        v.i = mk({4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, '0, 2'b11, 1, 1, 0);
        v.o.d0 = {4{32'h8000_0000}}; v.o.d1 = '0; v.o.st = stl(3'b001, 3'b001, 3'b001, 3'b001);
        tbl.push_back(v);
        v.name = "sat_neg";
        v.i = mk({4{32'h8000_0000}}, {4{32'hFFFF_FFFF}}, '0, 2'b11, 1, 1, 1);
        v.o.d0 = {4{32'h7FFF_FFFF}}; v.o.d1 = '0; v.o.st = stl(3'b101, 3'b101, 3'b101, 3'b101);
        tbl.push_back(v);
        v.name = "uns_wrap";
        v.i = mk({4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, '0, 2'b11, 0, 0, 0);
        v.o.d0 = '0; v.o.d1 = '0; v.o.st = stl(3'b011, 3'b011, 3'b011, 3'b011);
        tbl.push_back(v);
        v.name = "mixed";
        v.i = mk({64'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF}, {64'd0, 32'h8000_0000, 32'h0000_0001},
                 '0, 2'b11, 1, 0, 0);
        v.o.d0 = {64'd0, 32'hFFFF_FFFF, 32'd0}; v.o.d1 = '0;
        v.o.st = stl(3'b010, 3'b010, 3'b001, 3'b010);
        tbl.push_back(v);
        v.name = "n48_sgn";
        v.i = mk(128'hF, 128'h01, '0, 2'b00, 1, 1, 1);
        v.o = zero;
        tbl.push_back(v);
        v.name = "n48_uns";
        v.i = mk(128'hF, 128'hFF, '0, 2'b00, 0, 0, 0);
        v.o = zero; v.o.d0 = 128'h0E;
        tbl.push_back(v);
        v.name = "n48_hi";
        v.i = mk(128'h7 << 64, '0, 128'h80, 2'b00, 1, 1, 1);
        v.o = zero; v.o.d1 = 128'h87;
        tbl.push_back(v);
        v.name = "prec01";
        v.i = mk({4{32'h1234_5678}}, {4{32'h1111_1111}}, '1, 2'b01, 0, 0, 0);
        v.o = zero;
        tbl.push_back(v);
        v.name = "prec10";
        v.i = mk({4{32'h1234_5678}}, {4{32'h1111_1111}}, '1, 2'b10, 1, 1, 1);
        v.o = zero;
        tbl.push_back(v);

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", zero);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[k]) begin
            issue(tbl[k].i);
            check_out(tbl[k].name, tbl[k].o);
        end

        // Hold: outputs keep the last result while inputs churn with valid low.
        x = tbl[0].i;
        issue(x);
        held = tbl[0].o;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(rand_in(), 1'b0);
            @(posedge clk);
            #1;
            check_out("hold", held);
        end

        // Back-to-back valid instructions, each visible one cycle later.
        for (int c = 0; c < 3; c++) begin
            issue(tbl[c + 1].i);
            check_out("b2b", tbl[c + 1].o);
        end

        // Reset wins over a concurrent valid instruction.
        @(negedge clk);
        drive(tbl[1].i, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("rst_vs_valid", zero);
        @(negedge clk);
        rst = 1'b0;

        // Unsupported encoding clears a previously nonzero result.
        issue(tbl[5].i);
        check_out("pre_unsup", tbl[5].o);
        x = tbl[5].i; x.prec = 2'b01;
        issue(x);
        check_out("unsup_clear", zero);

        for (int n = 0; n < 300; n++) begin
            x = rand_in();
            issue(x);
            check_out("rand", model(x));
        end

        @(negedge clk);
        inst_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
